// File: rtl/round_shift_pkg.sv
// Shared types for the streaming divide-by-2^k rounder: rounding modes,
// default widths and the stage-1 record carried between pipeline stages.
package round_shift_pkg;

  localparam int RS_OUT_WIDTH = 32;
  localparam int RS_MAX_SHIFT = 8;
  localparam int RS_IN_WIDTH  = RS_OUT_WIDTH + RS_MAX_SHIFT;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,
    RND_HALF_UP   = 2'd1,
    RND_HALF_EVEN = 2'd2,
    RND_RSVD      = 2'd3
  } rnd_mode_e;

  // Everything stage 2 needs to finish the rounding of one beat.
  typedef struct packed {
    logic [RS_IN_WIDTH-1:0] q;
    logic                   r;
    logic                   s;
    logic                   lsb;
    rnd_mode_e              mode;
  } s1_data_t;

  // The reserved encoding behaves as half-up.
  function automatic logic round_incr(input rnd_mode_e m, input logic r,
                                      input logic s, input logic lsb);
    case (m)
      RND_TRUNC:     return 1'b0;
      RND_HALF_EVEN: return r & (s | lsb);
      default:       return r;
    endcase
  endfunction

endpackage

// File: rtl/round_incr_sat.sv
// Stage-2 datapath: apply the rounding increment to the shifted quotient and
// clamp to the output width, flagging any beat that had to be clamped.
module round_incr_sat
  import round_shift_pkg::*;
#(
  parameter int IN_WIDTH  = RS_IN_WIDTH,
  parameter int OUT_WIDTH = RS_OUT_WIDTH
) (
  input  logic [IN_WIDTH-1:0]  i_q,
  input  logic                 i_r,
  input  logic                 i_s,
  input  logic                 i_lsb,
  input  rnd_mode_e            i_mode,
  output logic [OUT_WIDTH-1:0] o_dout,
  output logic                 o_sat
);

  logic              w_inc;
  logic [IN_WIDTH:0] w_sum;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_inc  = round_incr(i_mode, i_r, i_s, i_lsb);
    // One extra bit so a rounding carry out of the quotient is never lost.
    w_sum  = {1'b0, i_q} + (IN_WIDTH + 1)'(w_inc);
    o_sat  = |w_sum[IN_WIDTH:OUT_WIDTH];
    o_dout = o_sat ? '1 : w_sum[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/round_shift_stream.sv
// Streaming unsigned divide-by-2^k with selectable rounding, output saturation,
// a two-stage valid/ready pipeline and a sticky saturation event counter.
module round_shift_stream
  import round_shift_pkg::*;
#(
  // Widths must agree with round_shift_pkg, which sizes the stage-1 record.
  parameter int OUT_WIDTH = RS_OUT_WIDTH,
  parameter int MAX_SHIFT = RS_MAX_SHIFT,
  parameter int IN_WIDTH  = OUT_WIDTH + MAX_SHIFT,
  parameter int CNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_WIDTH-1:0]            din,
  input  logic [$clog2(MAX_SHIFT+1)-1:0] shift,
  input  logic [1:0]                     mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_WIDTH-1:0]           dout,
  output logic                           sat,
  output logic [CNT_WIDTH-1:0]           sat_count
);

  localparam int SHIFT_W = $clog2(MAX_SHIFT + 1);

  logic                 r_s1_valid;
  s1_data_t             r_s1;
  logic                 r_s2_valid;
  logic [OUT_WIDTH-1:0] r_dout;
  logic                 r_sat;
  logic [CNT_WIDTH-1:0] r_sat_count;

  logic [SHIFT_W-1:0]   w_k;
  logic [IN_WIDTH-1:0]  w_q;
  s1_data_t             w_s1_next;
  logic                 w_s2_advance;
  logic                 w_in_ready;
  logic [OUT_WIDTH-1:0] w_dout;
  logic                 w_sat;

  always_comb begin
    w_s1_next = '0;
    w_k       = (int'(shift) > MAX_SHIFT) ? SHIFT_W'(MAX_SHIFT) : shift;
    w_q       = din >> w_k;
    // Round bit is din[k-1]; sticky ORs everything below it. Both vanish for
    // small k because the loop bounds never reach them.
    for (int i = 0; i < MAX_SHIFT; i++) begin
      if (i + 1 == int'(w_k)) w_s1_next.r = din[i];
      if (i + 1 <  int'(w_k)) w_s1_next.s = w_s1_next.s | din[i];
    end
    w_s1_next.q    = w_q;
    w_s1_next.lsb  = w_q[0];
    w_s1_next.mode = rnd_mode_e'(mode);
  end

  // A stage loads when it is empty or its contents move on this edge.
  assign w_s2_advance = !r_s2_valid || out_ready;
  assign w_in_ready   = !r_s1_valid || w_s2_advance;

  round_incr_sat #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_incr_sat (
    .i_q    (r_s1.q),
    .i_r    (r_s1.r),
    .i_s    (r_s1.s),
    .i_lsb  (r_s1.lsb),
    .i_mode (r_s1.mode),
    .o_dout (w_dout),
    .o_sat  (w_sat)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1        <= '0;
      r_s2_valid  <= 1'b0;
      r_dout      <= '0;
      r_sat       <= 1'b0;
      r_sat_count <= '0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) r_s1 <= w_s1_next;
      end
      if (w_s2_advance) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_dout <= w_dout;
          r_sat  <= w_sat;
        end
      end
      if (r_s2_valid && out_ready && r_sat && (r_sat_count != '1))
        r_sat_count <= r_sat_count + CNT_WIDTH'(1);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign dout      = r_dout;
  assign sat       = r_sat;
  assign sat_count = r_sat_count;

endmodule

// File: tb/tb_round_shift_stream.sv
// Directed bench for round_shift_stream: rounding vectors, saturation, clamped
// shift, back-to-back streaming, backpressure, mid-stream reset, counter limit.
module tb_round_shift_stream;

  localparam int OUT_W     = 32;
  localparam int MAX_SHIFT = 8;
  localparam int IN_W      = OUT_W + MAX_SHIFT;
  localparam int CNT_W     = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  din;
  logic [3:0]       shift;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] dout;
  logic             sat;
  logic [CNT_W-1:0] sat_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  round_shift_stream #(
    .OUT_WIDTH (OUT_W),
    .MAX_SHIFT (MAX_SHIFT),
    .IN_WIDTH  (IN_W),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .shift     (shift),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .sat       (sat),
    .sat_count (sat_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream beat i is (i*16 + 8) >> 4 with half-up rounding, i.e. i + 1.
  function automatic logic [IN_W-1:0] beat_din(input int i);
    return (IN_W'(i) << 4) | IN_W'(8);
  endfunction

  // Push one beat into an idle pipeline with out_ready high and check the result.
  task automatic one_beat(input string tag, input logic [IN_W-1:0] d, input logic [3:0] k,
                          input logic [1:0] m, input logic [OUT_W-1:0] exp_dout,
                          input logic exp_sat);
    int waited;
    @(posedge clk); #1;
    din = d; shift = k; mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 8) begin
      waited++;
      @(negedge clk);
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_dout"}, dout, exp_dout);
    check({tag, "_sat"}, sat, exp_sat);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int  sent;
    int  got;
    logic hs;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    din = '0; shift = '0; mode = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_dout", dout, '0);
    check("rst_sat", sat, 1'b0);
    check("rst_sat_count", sat_count, '0);
    check("rst_in_ready", in_ready, 1'b1);

    // Rounding modes, sticky bit and the k=1/k=2 edges.
    one_beat("d20_trunc", 40'd20, 4'd3, 2'd0, 32'd2, 1'b0);
    one_beat("d20_halfup", 40'd20, 4'd3, 2'd1, 32'd3, 1'b0);
    one_beat("d20_halfeven", 40'd20, 4'd3, 2'd2, 32'd2, 1'b0);
    one_beat("d20_rsvd", 40'd20, 4'd3, 2'd3, 32'd3, 1'b0);
    one_beat("d28_halfeven", 40'd28, 4'd3, 2'd2, 32'd4, 1'b0);
    one_beat("d27_halfeven", 40'd27, 4'd3, 2'd2, 32'd3, 1'b0);
    one_beat("d21_sticky", 40'd21, 4'd3, 2'd2, 32'd3, 1'b0);
    one_beat("d10_k2_even", 40'd10, 4'd2, 2'd2, 32'd2, 1'b0);
    one_beat("d7_k2_even", 40'd7, 4'd2, 2'd2, 32'd2, 1'b0);
    one_beat("d5_k1_even", 40'd5, 4'd1, 2'd2, 32'd2, 1'b0);
    one_beat("d5_k1_halfup", 40'd5, 4'd1, 2'd1, 32'd3, 1'b0);
    one_beat("d7_k1_even", 40'd7, 4'd1, 2'd2, 32'd4, 1'b0);

    // Rounding carry saturates; truncation of the same beat does not.
    one_beat("max_halfup", 40'hFF_FFFF_FFFF, 4'd8, 2'd1, 32'hFFFF_FFFF, 1'b1);
    one_beat("max_trunc", 40'hFF_FFFF_FFFF, 4'd8, 2'd0, 32'hFFFF_FFFF, 1'b0);
    check("sat_count_1", sat_count, 16'd1);

    // k=0 overflow, then a shift above MAX_SHIFT clamps to 8.
    one_beat("k0_overflow", 40'h1_0000_0000, 4'd0, 2'd0, 32'hFFFF_FFFF, 1'b1);
    one_beat("k9_clamp", 40'h1FF, 4'd9, 2'd1, 32'd2, 1'b0);
    check("sat_count_2", sat_count, 16'd2);

    // Ten back-to-back beats: out_valid two cycles after first in_valid, one per clock.
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (c < 10) begin
        in_valid = 1'b1; din = beat_din(c); shift = 4'd4; mode = 2'd1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 10) check($sformatf("b2b_in_ready_%0d", c), in_ready, 1'b1);
      check($sformatf("b2b_valid_%0d", c), out_valid, (c >= 2 && c < 12));
      if (c >= 2 && c < 12) check($sformatf("b2b_dout_%0d", c), dout, 64'(c - 1));
    end

    // Backpressure: out_ready low for 5 cycles while in_valid stays high.
    out_ready = 1'b0;
    sent = 0;
    got  = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; din = beat_din(0); shift = 4'd4; mode = 2'd1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      hs = in_ready;
      if (out_valid) check($sformatf("stall_dout_%0d", c), dout, 32'd1);
      @(posedge clk); #1;
      if (hs) begin
        sent++;
        din = beat_din(sent);
      end
    end
    @(negedge clk);
    check("stall_accepted", sent, 2);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 30 && got < 6; c++) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("rel_dout_%0d", got), dout, 64'(got + 1));
        got++;
      end
      @(posedge clk); #1;
      if (hs) begin
        sent++;
        if (sent < 6) din = beat_din(sent);
        else in_valid = 1'b0;
      end
    end
    check("rel_count", got, 6);
    repeat (3) @(negedge clk);
    check("rel_no_dup", out_valid, 1'b0);

    // Fill both stages with saturating beats, then reset mid-stream.
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; din = 40'h1_0000_0000; shift = 4'd0; mode = 2'd0;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("full_out_valid", out_valid, 1'b1);
    check("full_in_ready", in_ready, 1'b0);
    check("full_sat_count", sat_count, 16'd2);
    #1 reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sat_count", sat_count, '0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", in_ready, 1'b1);
    repeat (3) @(negedge clk);
    check("postrst_flushed", out_valid, 1'b0);

    // Saturating stream: 100 beats counted exactly, then 2^16+3 total hold at all-ones.
    @(posedge clk); #1;
    in_valid = 1'b1; din = 40'h1_0000_0000; shift = 4'd0; mode = 2'd0;
    repeat (100) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sat_count_100", sat_count, 16'd100);
    @(posedge clk); #1;
    in_valid = 1'b1;
    repeat ((1 << CNT_W) + 3 - 100) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sat_count_hold", sat_count, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
